mips_fetch_queue: RTL and testbench
===================================

# mips_fetch_queue

Parametrised instruction-fetch front end for the next-generation MIPS core. It owns the PC, issues one instruction-memory request at a time through a level handshake like the one the cache uses, and buffers fetched instructions with their PCs in a DEPTH-entry FIFO for decode. It supports redirects (branch/jump) with flush and drop of in-flight data, plus a sticky halt on syscall. It replaces the bare PC register plus `cache_done` stall used by the single-cycle core.

## Interface

- DEPTH, 4, queue entries; power of two, ≥2
- RESET_PC, 32'h0000_0000, first fetch address after reset
- clk  in  1  clock; all state updates on rising edge
- rst_b  in  1  reset, asynchronous, active-high
- imem_req  out  1  request valid; registered
- imem_addr  out  32  request word address; registered, stable while imem_req=1
- imem_ready  in  1  memory done; imem_data valid this cycle
- imem_data  in  32  fetched instruction
- redirect_valid  in  1  one-cycle pulse, flush and refetch
- redirect_pc  in  32  new fetch PC; bits [1:0] ignored, forced 0
- halt  in  1  syscall retired by decode; one-cycle pulse
- deq_ready  in  1  decode accepts head entry
- inst_valid  out  1  queue non-empty
- inst  out  32  head instruction
- inst_pc  out  32  head PC
- count  out  $clog2(DEPTH+1)  occupied entries
- halted  out  1  sticky halt flag

## Operation

- State:
  - FSM {IDLE, REQ, HALTED}
  - fetch_pc: next address to request
  - req_addr: drives imem_addr
  - drop: discard pending response
  - circular queue: head/tail pointers, count
- Start condition: `!halted && count_after_edge < DEPTH && !drop_pending_redirect_to_self`. At most one outstanding request.
- IDLE → REQ when start condition holds: req_addr←fetch_pc, fetch_pc←fetch_pc+4 (mod 2^32).
- REQ with imem_ready=1:
  - If drop=0 and no redirect/halt this cycle, enqueue {req_addr, imem_data}.
  - Clear drop.
  - Then start the next request immediately if the start condition holds (REQ→REQ back-to-back), else → IDLE.
- Redirect (any state except HALTED):
  - Queue flushed (count←0, head=tail).
  - fetch_pc←redirect_pc.
  - In REQ with imem_ready=0: drop←1, and the request is held unchanged until imem_ready.
  - In REQ with imem_ready=1: the response is discarded; the next request issues with redirect_pc.
- Halt: halted←1, queue flushed, FSM→HALTED once no request is pending. A pending request is completed and its data dropped; imem_req then falls. HALTED exits only via reset.
- Dequeue when inst_valid && deq_ready; head advances.
- Priority within one edge: halt > redirect > enqueue/dequeue.
- Simultaneous enqueue and dequeue: count unchanged, both pointers advance; legal at count=DEPTH only if a request was outstanding, which the start rule makes impossible. A dequeue with inst_valid=0 is ignored.

## Timing

- Reset values:
  - imem_req=0, imem_addr=RESET_PC
  - inst_valid=0, inst=0, inst_pc=0, count=0, halted=0
  - FSM=IDLE, fetch_pc=RESET_PC, drop=0
- Reset asserted mid-request abandons it; memory must tolerate imem_req dropping without ready.
- First rising edge after reset release: imem_req=1, imem_addr=RESET_PC.
- Request-to-visible latency: data accepted on edge N (imem_ready=1) gives inst_valid=1 and inst=data after edge N, with zero bubble into decode.
- Throughput: with imem_ready tied high and deq_ready high, one instruction per cycle and a sequential PC sequence.
- inst, inst_pc, inst_valid are combinational from queue head; no input-to-output combinational path.
- Redirect pulse at edge N: inst_valid=0 after N. First redirected instruction is visible one edge after its imem_ready.
- halted rises on the edge sampling halt=1.

## Test plan

- Streaming: reset released, imem_ready=1, deq_ready=1, imem_data=PC^32'hA5A5_0000 → imem_addr 0,4,8,… every cycle; inst_pc matches with a one-cycle lag; count stays ≤1.
- Backpressure: deq_ready=0, DEPTH=4 → exactly 4 enqueues, count=4, imem_req=0; raise deq_ready → requests resume; dequeue order is PC 0,4,8,C.
- Redirect mid-request: imem_ready held 0 for 3 cycles on addr 0x10, redirect_pc=0x200 at cycle 1 → addr stays 0x10 until ready; that data is never dequeued; next request is 0x200.
- Redirect coinciding with imem_ready on 0x20 → 0x20 data dropped, count=0, next imem_addr=redirect_pc.
- Halt: halt pulse with count=3 and a request pending → queue flushed; halted=1; pending response dropped; imem_req=0 forever; redirect ignored until reset.
- Async reset mid-REQ with count=2 → outputs take reset values immediately, without waiting for a clk edge; first post-reset request is RESET_PC=0x0040_0000 (parameter override).

Source files
------------

// File: rtl/mips_fetch_queue.sv
// Instruction-fetch front end: owns the PC, issues one imem request at a time,
// and buffers fetched {pc, instruction} pairs in a DEPTH-entry circular queue.
// Redirects flush the queue and drop any in-flight response; halt is sticky
// until reset.
module mips_fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic                       clk,
  input  logic                       rst_b,
  output logic                       imem_req,
  output logic [31:0]                imem_addr,
  input  logic                       imem_ready,
  input  logic [31:0]                imem_data,
  input  logic                       redirect_valid,
  input  logic [31:0]                redirect_pc,
  input  logic                       halt,
  input  logic                       deq_ready,
  output logic                       inst_valid,
  output logic [31:0]                inst,
  output logic [31:0]                inst_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       halted
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    REQ    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t        state_r, state_s;
  logic [31:0]   fetch_pc_r, fetch_pc_s;
  logic [31:0]   req_addr_r, req_addr_s;
  logic          req_r, req_s;
  logic          drop_r, drop_s;
  logic          halted_r, halted_s;
  logic [PW-1:0] head_r, head_s;
  logic [PW-1:0] tail_r, tail_s;
  logic [CW-1:0] count_r, count_s;
  logic [31:0]   pc_mem_r   [DEPTH];
  logic [31:0]   inst_mem_r [DEPTH];

  logic          redir_s;
  logic          resp_s;
  logic          enq_s;
  logic          deq_s;
  logic          flush_s;
  logic          busy_after_s;
  logic          start_ok_s;
  logic [31:0]   fetch_base_s;
  logic          unused_pc_bits_s;

  // Low address bits of a redirect target are always forced to zero.
  assign unused_pc_bits_s = ^redirect_pc[1:0];

  // Queue head drives decode directly; empty queue presents zeros.
  assign inst_valid = (count_r != {CW{1'b0}});
  assign inst       = inst_valid ? inst_mem_r[head_r] : 32'h0000_0000;
  assign inst_pc    = inst_valid ? pc_mem_r[head_r]   : 32'h0000_0000;
  assign count      = count_r;
  assign halted     = halted_r;
  assign imem_req   = req_r;
  assign imem_addr  = req_addr_r;

  // Next-state for FSM, PC, drop flag, queue pointers and occupancy.
  always_comb begin
    state_s    = state_r;
    fetch_pc_s = fetch_pc_r;
    req_addr_s = req_addr_r;
    req_s      = req_r;
    drop_s     = drop_r;
    halted_s   = halted_r;
    head_s     = head_r;
    tail_s     = tail_r;
    count_s    = count_r;

    // Halt outranks redirect; once halted, redirects are ignored.
    redir_s = redirect_valid && !halted_r && !halt;
    resp_s  = (state_r == REQ) && imem_ready;
    deq_s   = inst_valid && deq_ready;
    enq_s   = resp_s && !drop_r && !redir_s && !halt && !halted_r;
    flush_s = halt || redir_s;

    if (halt) begin
      halted_s = 1'b1;
    end else begin
      halted_s = halted_r;
    end

    if (redir_s) begin
      fetch_base_s = {redirect_pc[31:2], 2'b00};
    end else begin
      fetch_base_s = fetch_pc_r;
    end
    fetch_pc_s = fetch_base_s;

    // Occupancy and pointers; a flush empties the queue outright.
    if (flush_s) begin
      count_s = {CW{1'b0}};
      head_s  = {PW{1'b0}};
      tail_s  = {PW{1'b0}};
    end else begin
      if (enq_s && !deq_s) begin
        count_s = count_r + CW'(1);
      end else if (deq_s && !enq_s) begin
        count_s = count_r - CW'(1);
      end else begin
        count_s = count_r;
      end
      head_s = deq_s ? (head_r + PW'(1)) : head_r;
      tail_s = enq_s ? (tail_r + PW'(1)) : tail_r;
    end

    // A response still owed after a redirect/halt must be thrown away.
    if ((state_r == REQ) && !imem_ready && (redir_s || halt)) begin
      drop_s = 1'b1;
    end else if (resp_s) begin
      drop_s = 1'b0;
    end else begin
      drop_s = drop_r;
    end

    busy_after_s = (state_r == REQ) && !imem_ready;
    start_ok_s   = !halted_s && !busy_after_s && (state_r != HALTED) &&
                   (count_s < DEPTH_C);

    case (state_r)
      IDLE: begin
        if (halted_s) begin
          state_s = HALTED;
          req_s   = 1'b0;
        end else if (start_ok_s) begin
          state_s    = REQ;
          req_s      = 1'b1;
          req_addr_s = fetch_base_s;
          fetch_pc_s = fetch_base_s + 32'd4;
        end else begin
          state_s = IDLE;
          req_s   = 1'b0;
        end
      end
      REQ: begin
        if (!imem_ready) begin
          state_s = REQ;
          req_s   = 1'b1;
        end else if (halted_s) begin
          state_s = HALTED;
          req_s   = 1'b0;
        end else if (start_ok_s) begin
          state_s    = REQ;
          req_s      = 1'b1;
          req_addr_s = fetch_base_s;
          fetch_pc_s = fetch_base_s + 32'd4;
        end else begin
          state_s = IDLE;
          req_s   = 1'b0;
        end
      end
      HALTED: begin
        state_s = HALTED;
        req_s   = 1'b0;
      end
      default: begin
        state_s = IDLE;
        req_s   = 1'b0;
      end
    endcase
  end

  // Control and pointer registers.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      state_r    <= IDLE;
      fetch_pc_r <= RESET_PC;
      req_addr_r <= RESET_PC;
      req_r      <= 1'b0;
      drop_r     <= 1'b0;
      halted_r   <= 1'b0;
      head_r     <= {PW{1'b0}};
      tail_r     <= {PW{1'b0}};
      count_r    <= {CW{1'b0}};
    end else begin
      state_r    <= state_s;
      fetch_pc_r <= fetch_pc_s;
      req_addr_r <= req_addr_s;
      req_r      <= req_s;
      drop_r     <= drop_s;
      halted_r   <= halted_s;
      head_r     <= head_s;
      tail_r     <= tail_s;
      count_r    <= count_s;
    end
  end

  // Queue storage: write the accepted response at the tail slot.
  always_ff @(posedge clk or posedge rst_b) begin
    if (rst_b) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_mem_r[i]   <= 32'h0000_0000;
        inst_mem_r[i] <= 32'h0000_0000;
      end
    end else if (enq_s) begin
      pc_mem_r[tail_r]   <= req_addr_r;
      inst_mem_r[tail_r] <= imem_data;
    end
  end

endmodule

// File: tb/tb_mips_fetch_queue.sv
// Directed bench for mips_fetch_queue: streaming, backpressure, redirects,
// halt and asynchronous reset with a RESET_PC override.
module tb_mips_fetch_queue;

  logic        clk;
  logic        rst;
  logic        rst2;
  logic        imem_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        halt;
  logic        deq_ready;
  logic        use2;
  logic [31:0] imem_data;

  logic        imem_req,   imem_req2;
  logic [31:0] imem_addr,  imem_addr2;
  logic        inst_valid, inst_valid2;
  logic [31:0] inst,       inst2;
  logic [31:0] inst_pc,    inst_pc2;
  logic [2:0]  count,      count2;
  logic        halted,     halted2;

  int err_cnt = 0;
  int chk_cnt = 0;

  // Memory model: instruction word is the address xor a fixed pattern.
  assign imem_data = (use2 ? imem_addr2 : imem_addr) ^ 32'hA5A5_0000;

  mips_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .rst_b(rst),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .deq_ready(deq_ready),
    .inst_valid(inst_valid), .inst(inst), .inst_pc(inst_pc),
    .count(count), .halted(halted)
  );

  mips_fetch_queue #(.DEPTH(4), .RESET_PC(32'h0040_0000)) dut2 (
    .clk(clk), .rst_b(rst2),
    .imem_req(imem_req2), .imem_addr(imem_addr2),
    .imem_ready(imem_ready), .imem_data(imem_data),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .halt(halt), .deq_ready(deq_ready),
    .inst_valid(inst_valid2), .inst(inst2), .inst_pc(inst_pc2),
    .count(count2), .halted(halted2)
  );

  // Free-running 10-unit clock.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
    chk_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #2;
    rst = 1'b0;
  endtask

  // Watchdog so the run always ends.
  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; rst2 = 1'b1; use2 = 1'b0;
    imem_ready = 1'b0; deq_ready = 1'b0; redirect_valid = 1'b0;
    redirect_pc = 32'h0; halt = 1'b0;
    #1;
    check_val("rst_req",    {31'h0, imem_req},   32'h0);
    check_val("rst_addr",   imem_addr,           32'h0);
    check_val("rst_valid",  {31'h0, inst_valid}, 32'h0);
    check_val("rst_inst",   inst,                32'h0);
    check_val("rst_pc",     inst_pc,             32'h0);
    check_val("rst_count",  {29'h0, count},      32'h0);
    check_val("rst_halted", {31'h0, halted},     32'h0);

    // Streaming with both handshakes high.
    imem_ready = 1'b1; deq_ready = 1'b1;
    #1 rst = 1'b0;
    step();
    check_val("st_first_req",  {31'h0, imem_req},   32'h1);
    check_val("st_first_addr", imem_addr,           32'h0);
    check_val("st_first_vld",  {31'h0, inst_valid}, 32'h0);
    for (int i = 1; i <= 6; i++) begin
      step();
      check_val("st_addr",  imem_addr,           32'(4 * i));
      check_val("st_valid", {31'h0, inst_valid}, 32'h1);
      check_val("st_pc",    inst_pc,             32'(4 * (i - 1)));
      check_val("st_inst",  inst,                32'(4 * (i - 1)) ^ 32'hA5A5_0000);
      check_val("st_count", {29'h0, count},      32'h1);
    end

    // Backpressure: queue fills to 4 and fetch stalls.
    deq_ready = 1'b0;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_val("bp_count", {29'h0, count},    32'h4);
    check_val("bp_req",   {31'h0, imem_req}, 32'h0);
    step();
    check_val("bp_req_hold", {31'h0, imem_req}, 32'h0);
    check_val("bp_cnt_hold", {29'h0, count},    32'h4);
    deq_ready = 1'b1;
    for (int k = 0; k < 5; k++) begin
      check_val("bp_order", inst_pc, 32'(4 * k));
      step();
      if (k == 0) begin
        check_val("bp_resume_req",  {31'h0, imem_req}, 32'h1);
        check_val("bp_resume_addr", imem_addr,         32'h10);
        check_val("bp_resume_cnt",  {29'h0, count},    32'h3);
      end
    end
    check_val("bp_end_cnt",  {29'h0, count}, 32'h3);
    check_val("bp_end_addr", imem_addr,      32'h20);

    // Redirect while a request is stalled on 0x10.
    deq_ready = 1'b1; imem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 5; i++) step();
    check_val("rm_addr10", imem_addr, 32'h10);
    check_val("rm_headC",  inst_pc,   32'hC);
    imem_ready = 1'b0; redirect_valid = 1'b1; redirect_pc = 32'h200;
    step();
    redirect_valid = 1'b0;
    check_val("rm_flush_vld", {31'h0, inst_valid}, 32'h0);
    check_val("rm_flush_cnt", {29'h0, count},      32'h0);
    check_val("rm_hold_addr", imem_addr,           32'h10);
    check_val("rm_hold_req",  {31'h0, imem_req},   32'h1);
    step();
    step();
    check_val("rm_hold_addr2", imem_addr,         32'h10);
    check_val("rm_hold_req2",  {31'h0, imem_req}, 32'h1);
    imem_ready = 1'b1;
    step();
    check_val("rm_new_addr", imem_addr,           32'h200);
    check_val("rm_dropped",  {31'h0, inst_valid}, 32'h0);
    step();
    check_val("rm_vld",  {31'h0, inst_valid}, 32'h1);
    check_val("rm_pc",   inst_pc,             32'h200);
    check_val("rm_inst", inst,                32'hA5A5_0200);

    // Redirect on the same edge the 0x20 response arrives; low bits masked.
    do_reset();
    for (int i = 0; i < 9; i++) step();
    check_val("rr_addr20", imem_addr, 32'h20);
    redirect_valid = 1'b1; redirect_pc = 32'h302;
    step();
    redirect_valid = 1'b0;
    check_val("rr_cnt",  {29'h0, count},      32'h0);
    check_val("rr_vld",  {31'h0, inst_valid}, 32'h0);
    check_val("rr_addr", imem_addr,           32'h300);
    check_val("rr_req",  {31'h0, imem_req},   32'h1);
    step();
    check_val("rr_pc",    inst_pc,   32'h300);
    check_val("rr_inst",  inst,      32'hA5A5_0300);
    check_val("rr_addr2", imem_addr, 32'h304);

    // Halt with three queued entries and a request pending.
    deq_ready = 1'b0; imem_ready = 1'b1;
    do_reset();
    for (int i = 0; i < 4; i++) step();
    check_val("h_pre_cnt", {29'h0, count}, 32'h3);
    imem_ready = 1'b0; halt = 1'b1;
    step();
    halt = 1'b0;
    check_val("h_halted", {31'h0, halted},     32'h1);
    check_val("h_cnt",    {29'h0, count},      32'h0);
    check_val("h_vld",    {31'h0, inst_valid}, 32'h0);
    check_val("h_pend",   {31'h0, imem_req},   32'h1);
    check_val("h_addr",   imem_addr,           32'hC);
    step();
    imem_ready = 1'b1;
    step();
    check_val("h_req_fall", {31'h0, imem_req},   32'h0);
    check_val("h_cnt2",     {29'h0, count},      32'h0);
    check_val("h_vld2",     {31'h0, inst_valid}, 32'h0);
    redirect_valid = 1'b1; redirect_pc = 32'h500; deq_ready = 1'b1;
    step();
    redirect_valid = 1'b0;
    check_val("h_redir_req", {31'h0, imem_req},   32'h0);
    check_val("h_redir_vld", {31'h0, inst_valid}, 32'h0);
    check_val("h_sticky",    {31'h0, halted},     32'h1);
    for (int i = 0; i < 3; i++) step();
    check_val("h_req_forever", {31'h0, imem_req}, 32'h0);

    // Asynchronous reset mid-request on the RESET_PC-override instance.
    use2 = 1'b1; imem_ready = 1'b1; deq_ready = 1'b0;
    rst2 = 1'b0;
    for (int i = 0; i < 3; i++) step();
    check_val("ar_cnt2", {29'h0, count2}, 32'h2);
    imem_ready = 1'b0;
    step();
    check_val("ar_pend_req",  {31'h0, imem_req2}, 32'h1);
    check_val("ar_pend_addr", imem_addr2,         32'h0040_0008);
    rst2 = 1'b1;
    #1;
    check_val("ar_req",    {31'h0, imem_req2},   32'h0);
    check_val("ar_addr",   imem_addr2,           32'h0040_0000);
    check_val("ar_vld",    {31'h0, inst_valid2}, 32'h0);
    check_val("ar_inst",   inst2,                32'h0);
    check_val("ar_pc",     inst_pc2,             32'h0);
    check_val("ar_cnt",    {29'h0, count2},      32'h0);
    check_val("ar_halted", {31'h0, halted2},     32'h0);
    #1;
    rst2 = 1'b0; imem_ready = 1'b1;
    step();
    check_val("ar_first_req",  {31'h0, imem_req2}, 32'h1);
    check_val("ar_first_addr", imem_addr2,         32'h0040_0000);

    $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
    $finish;
  end

endmodule
